sys_seq_ctrl: RTL and testbench

//  Sequencer for the SYS_ROW x SYS_COL systolic array built from sys_row/pe.
//  Per command it streams one weight row per beat into the array (w_wen), commits the

---
 rtl/sys_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sys_seq_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_seq_ctrl.sv
// sys_seq_ctrl: control sequencer for the SYS_ROW x SYS_COL systolic array.
// Per command: optional weight-row load and commit, skewed activation issue,
// then a fixed drain wait before the done pulse. Data paths bypass this block.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_load_w, cmd_len load-weights flag, number of activation vectors
//   w_valid/w_ready     weight-row buffer handshake
//   in_valid/in_ready   activation buffer handshake
//   w_wen               per-column weight shift enable into row 0
//   global_w_wen        per-column shadow-to-active weight commit
//   w_invalid           active weights not yet loaded
//   en_row              skewed compute enable, one bit per row
//   busy, done, err     status; done and err are one-cycle pulses
module sys_seq_ctrl #(
    parameter int SYS_ROW   = 16,
    parameter int SYS_COL   = 16,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_load_w,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SYS_COL-1:0]   w_wen,
    output logic [SYS_COL-1:0]   global_w_wen,
    output logic                 w_invalid,
    output logic [SYS_ROW-1:0]   en_row,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int DRAIN_LAT = SYS_ROW + SYS_COL - 1;
    localparam int BW        = $clog2(SYS_ROW) + 1;
    localparam int DW        = $clog2(DRAIN_LAT) + 1;

    localparam logic [BW-1:0] BEAT_LAST  = BW'(SYS_ROW - 1);
    // DRAIN is entered one cycle after the last handshake and done is
    // registered, so the exit decision is taken DRAIN_LAT-2 cycles in.
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LAT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_WCOMMIT,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] issued;
    logic [BW-1:0]        beat_cnt;
    logic [DW-1:0]        drain_cnt;
    logic [SYS_ROW-2:0]   skew;

    logic cmd_fire;
    logic w_fire;
    logic in_fire;

    assign cmd_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign w_ready      = (state == S_WLOAD);
    assign in_ready     = (state == S_COMPUTE) && (issued < len_q);

    assign cmd_fire     = cmd_valid & cmd_ready;
    assign w_fire       = w_valid & w_ready;
    assign in_fire      = in_valid & in_ready;

    assign w_wen        = {SYS_COL{w_fire}};
    assign global_w_wen = {SYS_COL{state == S_WCOMMIT}};

    // Row 0 is enabled combinationally by the pop; rows below see it
    // one cycle later per row, bubbles included.
    assign en_row       = {skew, in_fire};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            issued    <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            skew      <= '0;
            w_invalid <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            skew <= (skew << 1) | (SYS_ROW-1)'(in_fire);

            unique case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        len_q    <= cmd_len;
                        issued   <= '0;
                        beat_cnt <= '0;
                        if (cmd_load_w) begin
                            state <= S_WLOAD;
                        end else if (w_invalid) begin
                            err <= 1'b1;
                        end else if (cmd_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_COMPUTE;
                        end
                    end
                end

                S_WLOAD: begin
                    if (w_fire) begin
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt <= '0;
                            state    <= S_WCOMMIT;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end

                S_WCOMMIT: begin
                    w_invalid <= 1'b0;
                    if (len_q == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_COMPUTE;
                    end
                end

                S_COMPUTE: begin
                    if (in_fire) begin
                        issued <= issued + LEN_WIDTH'(1);
                        if (issued == len_q - LEN_WIDTH'(1)) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_seq_ctrl.sv
// tb_sys_seq_ctrl: directed bench for sys_seq_ctrl with a 4x4 array.
// Each cycle: inputs driven 1ns after posedge, outputs sampled 2ns later.
module tb_sys_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_load_w;
    logic [15:0] cmd_len;
    logic        w_valid;
    logic        w_ready;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  w_wen;
    logic [3:0]  global_w_wen;
    logic        w_invalid;
    logic [3:0]  en_row;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sys_seq_ctrl #(
        .SYS_ROW   (4),
        .SYS_COL   (4),
        .LEN_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_load_w   (cmd_load_w),
        .cmd_len      (cmd_len),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .w_wen        (w_wen),
        .global_w_wen (global_w_wen),
        .w_invalid    (w_invalid),
        .en_row       (en_row),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_load_w = 1'b0;
        cmd_len    = '0;
        w_valid    = 1'b0;
        in_valid   = 1'b0;
        adv();
        adv();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_load_w = 1'b0;
        cmd_len    = '0;
        w_valid    = 1'b0;
        in_valid   = 1'b0;
        adv();
        #2;
        checks++;
        if ({cmd_ready, w_invalid, busy, done, err} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_status got rdy/inv/busy/done/err=%b exp 11000",
                     {cmd_ready, w_invalid, busy, done, err});
        end
        checks++;
        if ({w_ready, in_ready, w_wen, global_w_wen, en_row} !== 14'h0) begin
            errors++;
            $display("FAIL reset_ctrl got %h exp 0",
                     {w_ready, in_ready, w_wen, global_w_wen, en_row});
        end
        adv();
        rst = 1'b0;
    endtask

    // load_w=1 len=3, buffers always ready; handshake at cycle 0
    task automatic test_basic();
        logic [3:0] e_wen, e_g, e_en;
        logic       e_ir, e_done, e_busy, e_inv;
        do_reset();
        adv();
        cmd_valid  = 1'b1;
        cmd_load_w = 1'b1;
        cmd_len    = 16'd3;
        w_valid    = 1'b1;
        in_valid   = 1'b1;
        #2;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_cmd_ready got %b exp 1", cmd_ready);
        end
        for (int k = 1; k <= 16; k++) begin
            adv();
            cmd_valid = 1'b0;
            #2;
            e_wen  = (k >= 1 && k <= 4) ? 4'hF : 4'h0;
            e_g    = (k == 5) ? 4'hF : 4'h0;
            e_ir   = (k >= 6 && k <= 8);
            e_done = (k == 15);
            e_busy = (k <= 14);
            e_inv  = (k <= 5);
            for (int r = 0; r < 4; r++)
                e_en[r] = (k - r >= 6) && (k - r <= 8);
            checks++;
            if (w_wen !== e_wen) begin
                errors++;
                $display("FAIL basic_wen cyc %0d got %h exp %h", k, w_wen, e_wen);
            end
            checks++;
            if (global_w_wen !== e_g) begin
                errors++;
                $display("FAIL basic_gwen cyc %0d got %h exp %h", k, global_w_wen, e_g);
            end
            checks++;
            if (en_row !== e_en) begin
                errors++;
                $display("FAIL basic_en_row cyc %0d got %b exp %b", k, en_row, e_en);
            end
            checks++;
            if (in_ready !== e_ir) begin
                errors++;
                $display("FAIL basic_in_ready cyc %0d got %b exp %b", k, in_ready, e_ir);
            end
            checks++;
            if (done !== e_done) begin
                errors++;
                $display("FAIL basic_done cyc %0d got %b exp %b", k, done, e_done);
            end
            checks++;
            if (busy !== e_busy || cmd_ready !== !e_busy) begin
                errors++;
                $display("FAIL basic_busy cyc %0d got busy=%b rdy=%b exp busy=%b",
                         k, busy, cmd_ready, e_busy);
            end
            checks++;
            if (w_invalid !== e_inv) begin
                errors++;
                $display("FAIL basic_w_invalid cyc %0d got %b exp %b", k, w_invalid, e_inv);
            end
        end
    endtask

    // w_valid low on cycles 3 and 4 of the load; len=1
    task automatic test_stall();
        logic [3:0] e_wen, e_g;
        logic       e_wr, e_ir, e_done;
        adv();
        cmd_valid  = 1'b1;
        cmd_load_w = 1'b1;
        cmd_len    = 16'd1;
        in_valid   = 1'b1;
        #2;
        for (int k = 1; k <= 16; k++) begin
            adv();
            cmd_valid = 1'b0;
            w_valid   = !(k == 3 || k == 4);
            #2;
            e_wen  = (k == 1 || k == 2 || k == 5 || k == 6) ? 4'hF : 4'h0;
            e_wr   = (k >= 1 && k <= 6);
            e_g    = (k == 7) ? 4'hF : 4'h0;
            e_ir   = (k == 8);
            e_done = (k == 15);
            checks++;
            if (w_wen !== e_wen) begin
                errors++;
                $display("FAIL stall_wen cyc %0d got %h exp %h", k, w_wen, e_wen);
            end
            checks++;
            if (w_ready !== e_wr) begin
                errors++;
                $display("FAIL stall_w_ready cyc %0d got %b exp %b", k, w_ready, e_wr);
            end
            checks++;
            if (global_w_wen !== e_g) begin
                errors++;
                $display("FAIL stall_gwen cyc %0d got %h exp %h", k, global_w_wen, e_g);
            end
            checks++;
            if (in_ready !== e_ir) begin
                errors++;
                $display("FAIL stall_in_ready cyc %0d got %b exp %b", k, in_ready, e_ir);
            end
            checks++;
            if (done !== e_done) begin
                errors++;
                $display("FAIL stall_done cyc %0d got %b exp %b", k, done, e_done);
            end
        end
        w_valid = 1'b1;
    endtask

    // weights already valid; load_w=0 len=2, in_valid 1,0,1 in cycles 1..3
    task automatic test_bubbles();
        logic [3:0] pat_bits;
        logic [3:0] e_en;
        logic       e_ir, e_done;
        pat_bits = 4'b1010;
        adv();
        cmd_valid  = 1'b1;
        cmd_load_w = 1'b0;
        cmd_len    = 16'd2;
        in_valid   = 1'b0;
        #2;
        for (int k = 1; k <= 11; k++) begin
            adv();
            cmd_valid = 1'b0;
            in_valid  = (k <= 3) ? pat_bits[k] : 1'b0;
            #2;
            for (int r = 0; r < 4; r++)
                e_en[r] = (k - r >= 1 && k - r <= 3) ? pat_bits[k-r] : 1'b0;
            e_ir   = (k >= 1 && k <= 3);
            e_done = (k == 10);
            checks++;
            if (en_row !== e_en) begin
                errors++;
                $display("FAIL bubble_en_row cyc %0d got %b exp %b", k, en_row, e_en);
            end
            checks++;
            if (in_ready !== e_ir) begin
                errors++;
                $display("FAIL bubble_in_ready cyc %0d got %b exp %b", k, in_ready, e_ir);
            end
            checks++;
            if (done !== e_done) begin
                errors++;
                $display("FAIL bubble_done cyc %0d got %b exp %b", k, done, e_done);
            end
        end
    endtask

    // compute without weights after reset
    task automatic test_err();
        do_reset();
        adv();
        cmd_valid  = 1'b1;
        cmd_load_w = 1'b0;
        cmd_len    = 16'd5;
        in_valid   = 1'b1;
        #2;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_early got %b exp 0", err);
        end
        for (int k = 1; k <= 4; k++) begin
            adv();
            cmd_valid = 1'b0;
            #2;
            checks++;
            if (err !== (k == 1)) begin
                errors++;
                $display("FAIL err_pulse cyc %0d got %b exp %b", k, err, (k == 1));
            end
            checks++;
            if ({cmd_ready, busy, in_ready, en_row, done} !== 8'b1000_0000) begin
                errors++;
                $display("FAIL err_idle cyc %0d got rdy/busy/ir/en/done=%b exp 10000000",
                         k, {cmd_ready, busy, in_ready, en_row, done});
            end
        end
    endtask

    // load_w=1 len=0: load, commit, done, no compute
    task automatic test_len0();
        logic [3:0] e_wen, e_g;
        logic       e_done, e_rdy;
        adv();
        cmd_valid  = 1'b1;
        cmd_load_w = 1'b1;
        cmd_len    = 16'd0;
        w_valid    = 1'b1;
        in_valid   = 1'b1;
        #2;
        for (int k = 1; k <= 8; k++) begin
            adv();
            cmd_valid = 1'b0;
            #2;
            e_wen  = (k >= 1 && k <= 4) ? 4'hF : 4'h0;
            e_g    = (k == 5) ? 4'hF : 4'h0;
            e_done = (k == 6);
            e_rdy  = (k >= 7);
            checks++;
            if (w_wen !== e_wen || global_w_wen !== e_g) begin
                errors++;
                $display("FAIL len0_wen cyc %0d got wen=%h g=%h exp wen=%h g=%h",
                         k, w_wen, global_w_wen, e_wen, e_g);
            end
            checks++;
            if (done !== e_done) begin
                errors++;
                $display("FAIL len0_done cyc %0d got %b exp %b", k, done, e_done);
            end
            checks++;
            if (en_row !== 4'h0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL len0_compute cyc %0d got en=%b ir=%b exp 0000 0",
                         k, en_row, in_ready);
            end
            checks++;
            if (cmd_ready !== e_rdy) begin
                errors++;
                $display("FAIL len0_cmd_ready cyc %0d got %b exp %b", k, cmd_ready, e_rdy);
            end
        end
        checks++;
        if (w_invalid !== 1'b0) begin
            errors++;
            $display("FAIL len0_w_invalid got %b exp 0", w_invalid);
        end
    endtask

    // async reset in the middle of a long compute
    task automatic test_reset_mid();
        adv();
        cmd_valid  = 1'b1;
        cmd_load_w = 1'b0;
        cmd_len    = 16'd10;
        in_valid   = 1'b1;
        #2;
        for (int k = 1; k <= 3; k++) begin
            adv();
            cmd_valid = 1'b0;
        end
        #2;
        checks++;
        if (en_row !== 4'b0111) begin
            errors++;
            $display("FAIL rstmid_pre_en got %b exp 0111", en_row);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (en_row !== 4'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_en got en=%b ir=%b exp 0000 0", en_row, in_ready);
        end
        checks++;
        if ({w_invalid, cmd_ready, busy} !== 3'b110) begin
            errors++;
            $display("FAIL rstmid_status got inv/rdy/busy=%b exp 110",
                     {w_invalid, cmd_ready, busy});
        end
        adv();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            adv();
            #2;
            checks++;
            if (done !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_done cyc %0d got done=%b err=%b exp 0 0",
                         k, done, err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_bubbles();
        test_err();
        test_len0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
